// File: rtl/calc_key_sequencer.sv
// calc_key_sequencer: keypad entry sequencer feeding two 3-digit BCD operands and an op to the ALU
module calc_key_sequencer #(
  parameter int MAX_DIGITS = 3,
  parameter int ALU_LAT = 2
) (
  input  logic        clk,
  input  logic        clear,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic [15:0] alu_bcd_out,
  input  logic        alu_special,
  output logic [15:0] bcd1,
  output logic [15:0] bcd2,
  output logic [1:0]  op_selected,
  output logic [1:0]  alu_enable,
  output logic [15:0] display_bcd,
  output logic        neg_led,
  output logic        busy
);
  typedef enum logic [2:0] {S_A, S_B, S_EXEC, S_WAIT, S_RES} state_t;
  localparam int WW = $clog2(ALU_LAT + 1);
  localparam logic [1:0] MAXD = 2'(MAX_DIGITS);
  localparam logic [WW-1:0] LAST = WW'(ALU_LAT - 1);
  state_t state_q, state_d;
  logic [11:0] a_q, a_d, b_q, b_d;
  logic [1:0] op_q, op_d, cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
  logic [WW-1:0] wait_q, wait_d;
  logic digit, opk, clr, eq, wipe;
  logic [1:0] opv;
  assign digit = key_valid && key_code <= 4'd9;
  assign opk = key_valid && (key_code == 4'hA || key_code == 4'hB);
  assign clr = key_valid && key_code == 4'hC;
  assign eq = key_valid && key_code == 4'hE;
  assign opv = key_code == 4'hA ? 2'b01 : 2'b10;
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    op_d = op_q;
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    wait_d = wait_q;
    alu_enable = 2'b00;
    wipe = 1'b0;
    case (state_q)
      S_A: begin
        if (digit && cnt_a_q < MAXD) begin
          a_d = {a_q[7:0], key_code};
          cnt_a_d = cnt_a_q + 2'd1;
        end else if (opk) begin
          op_d = opv;
          b_d = '0;
          cnt_b_d = '0;
          state_d = S_B;
        end else if (clr) begin
          a_d = '0;
          cnt_a_d = '0;
        end
      end
      S_B: begin
        if (digit && cnt_b_q < MAXD) begin
          b_d = {b_q[7:0], key_code};
          cnt_b_d = cnt_b_q + 2'd1;
        end else if (opk && cnt_b_q == 2'd0) op_d = opv;
        else if (eq && cnt_b_q != 2'd0) state_d = S_EXEC;
        else if (clr) wipe = 1'b1;
      end
      S_EXEC: begin
        alu_enable = 2'b01;
        wait_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (clr) wipe = 1'b1;
        else if (wait_q == LAST) state_d = S_RES;
        else wait_d = wait_q + 1'b1;
      end
      S_RES: begin
        if (digit) begin
          a_d = {8'b0, key_code};
          cnt_a_d = 2'd1;
          b_d = '0;
          cnt_b_d = '0;
          op_d = 2'b00;
          state_d = S_A;
        end else if (opk && !alu_special) begin
          // chained result becomes operand A and counts as a full entry
          a_d = alu_bcd_out[11:0];
          cnt_a_d = MAXD;
          op_d = opv;
          b_d = '0;
          cnt_b_d = '0;
          state_d = S_B;
        end else if (clr) wipe = 1'b1;
      end
      default: wipe = 1'b1;
    endcase
    if (wipe) begin
      state_d = S_A;
      a_d = '0;
      b_d = '0;
      op_d = 2'b00;
      cnt_a_d = '0;
      cnt_b_d = '0;
      wait_d = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= S_A;
      a_q <= '0;
      b_q <= '0;
      op_q <= 2'b00;
      cnt_a_q <= '0;
      cnt_b_q <= '0;
      wait_q <= '0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      op_q <= op_d;
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
      wait_q <= wait_d;
    end
  end
  assign bcd1 = {4'b0, a_q};
  assign bcd2 = {4'b0, b_q};
  assign op_selected = op_q;
  assign busy = state_q == S_EXEC || state_q == S_WAIT;
  assign neg_led = state_q == S_RES && alu_special;
  assign display_bcd = state_q == S_RES ? alu_bcd_out :
                       state_q == S_A ? bcd1 :
                       state_q == S_B ? (cnt_b_q == 2'd0 ? bcd1 : bcd2) : bcd2;
endmodule

// File: tb/tb_calc_key_sequencer.sv
// tb_calc_key_sequencer: directed scenario tests for the keypad sequencer
module tb_calc_key_sequencer;
  logic clk = 1'b0, clear, key_valid, alu_special, neg_led, busy;
  logic [3:0] key_code;
  logic [15:0] alu_bcd_out, bcd1, bcd2, display_bcd;
  logic [1:0] op_selected, alu_enable;
  int n_chk = 0, n_fail = 0, pulses = 0, p0;

  calc_key_sequencer #(.MAX_DIGITS(3), .ALU_LAT(2)) dut (
    .clk(clk), .clear(clear), .key_valid(key_valid), .key_code(key_code),
    .alu_bcd_out(alu_bcd_out), .alu_special(alu_special), .bcd1(bcd1), .bcd2(bcd2),
    .op_selected(op_selected), .alu_enable(alu_enable), .display_bcd(display_bcd),
    .neg_led(neg_led), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (alu_enable == 2'b01) pulses++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic key(input logic [3:0] k);
    key_valid = 1'b1;
    key_code = k;
    tick();
    key_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    n_chk++; if (bcd1 !== 16'h0 || bcd2 !== 16'h0) begin n_fail++; $display("FAIL reset_operands got %h/%h exp 0000/0000", bcd1, bcd2); end
    n_chk++; if (op_selected !== 2'b00 || alu_enable !== 2'b00) begin n_fail++; $display("FAIL reset_op_en got %b/%b exp 00/00", op_selected, alu_enable); end
    n_chk++; if (display_bcd !== 16'h0 || neg_led !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_disp got %h/%b/%b exp 0000/0/0", display_bcd, neg_led, busy); end
  endtask

  task automatic test_add();
    do_clear();
    key(4'd1); key(4'd2); key(4'd3);
    n_chk++; if (bcd1 !== 16'h0123 || display_bcd !== 16'h0123) begin n_fail++; $display("FAIL t1_a got %h/%h exp 0123/0123", bcd1, display_bcd); end
    key(4'hA);
    n_chk++; if (op_selected !== 2'b01 || display_bcd !== 16'h0123) begin n_fail++; $display("FAIL t1_op got %b/%h exp 01/0123", op_selected, display_bcd); end
    key(4'd4); key(4'd5);
    n_chk++; if (bcd2 !== 16'h0045 || display_bcd !== 16'h0045) begin n_fail++; $display("FAIL t1_b got %h/%h exp 0045/0045", bcd2, display_bcd); end
    alu_bcd_out = 16'h0168; alu_special = 1'b0; p0 = pulses;
    key(4'hE);
    n_chk++; if (alu_enable !== 2'b01 || busy !== 1'b1) begin n_fail++; $display("FAIL t1_exec got %b/%b exp 01/1", alu_enable, busy); end
    tick();
    n_chk++; if (alu_enable !== 2'b00 || busy !== 1'b1 || display_bcd !== 16'h0045) begin n_fail++; $display("FAIL t1_wait got %b/%b/%h exp 00/1/0045", alu_enable, busy, display_bcd); end
    tick();
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL t1_wait2 got busy %b exp 1", busy); end
    tick();
    n_chk++; if (display_bcd !== 16'h0168 || neg_led !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL t1_res got %h/%b/%b exp 0168/0/0", display_bcd, neg_led, busy); end
    n_chk++; if (pulses - p0 !== 1) begin n_fail++; $display("FAIL t1_pulses got %0d exp 1", pulses - p0); end
    n_chk++; if (bcd1 !== 16'h0123 || bcd2 !== 16'h0045 || op_selected !== 2'b01) begin n_fail++; $display("FAIL t1_hold got %h/%h/%b exp 0123/0045/01", bcd1, bcd2, op_selected); end
    key(4'd7);
    n_chk++; if (bcd1 !== 16'h0007 || bcd2 !== 16'h0 || op_selected !== 2'b00 || display_bcd !== 16'h0007) begin n_fail++; $display("FAIL res_digit got %h/%h/%b/%h exp 0007/0000/00/0007", bcd1, bcd2, op_selected, display_bcd); end
  endtask

  task automatic test_sub_neg();
    do_clear();
    key(4'd1); key(4'd2); key(4'hB); key(4'd4); key(4'd5);
    alu_bcd_out = 16'h0033; alu_special = 1'b1;
    key(4'hE); tick(); tick(); tick();
    n_chk++; if (display_bcd !== 16'h0033 || neg_led !== 1'b1) begin n_fail++; $display("FAIL t2_res got %h/%b exp 0033/1", display_bcd, neg_led); end
    key(4'hA);
    n_chk++; if (neg_led !== 1'b1 || op_selected !== 2'b10 || busy !== 1'b0 || bcd1 !== 16'h0012) begin n_fail++; $display("FAIL t2_ignoreA got %b/%b/%b/%h exp 1/10/0/0012", neg_led, op_selected, busy, bcd1); end
    key(4'hE);
    n_chk++; if (alu_enable !== 2'b00 || neg_led !== 1'b1) begin n_fail++; $display("FAIL t2_ignoreE got %b/%b exp 00/1", alu_enable, neg_led); end
    alu_special = 1'b0;
  endtask

  task automatic test_digit_limit();
    do_clear();
    key(4'd9); key(4'd9); key(4'd9); key(4'd9);
    n_chk++; if (bcd1 !== 16'h0999) begin n_fail++; $display("FAIL t3_drop got %h exp 0999", bcd1); end
    key(4'hA); key(4'd9); key(4'd9); key(4'd9); key(4'd8);
    n_chk++; if (bcd2 !== 16'h0999) begin n_fail++; $display("FAIL t3_dropb got %h exp 0999", bcd2); end
    alu_bcd_out = 16'h1998;
    key(4'hE); tick(); tick(); tick();
    n_chk++; if (display_bcd !== 16'h1998) begin n_fail++; $display("FAIL t3_res got %h exp 1998", display_bcd); end
  endtask

  task automatic test_chain();
    do_clear();
    key(4'd5); key(4'hA); key(4'd5);
    alu_bcd_out = 16'h0010;
    key(4'hE); tick(); tick(); tick();
    key(4'hA);
    n_chk++; if (bcd1 !== 16'h0010 || op_selected !== 2'b01 || display_bcd !== 16'h0010 || bcd2 !== 16'h0) begin n_fail++; $display("FAIL t4_chain got %h/%b/%h/%h exp 0010/01/0010/0000", bcd1, op_selected, display_bcd, bcd2); end
    key(4'd7);
    n_chk++; if (bcd1 !== 16'h0010 || bcd2 !== 16'h0007 || display_bcd !== 16'h0007) begin n_fail++; $display("FAIL t4_b got %h/%h/%h exp 0010/0007/0007", bcd1, bcd2, display_bcd); end
    alu_bcd_out = 16'h0017;
    key(4'hE); tick(); tick(); tick();
    n_chk++; if (display_bcd !== 16'h0017) begin n_fail++; $display("FAIL t4_res got %h exp 0017", display_bcd); end
  endtask

  task automatic test_busy_keys();
    do_clear();
    key(4'd1); key(4'hA); key(4'd2);
    alu_bcd_out = 16'h0003; p0 = pulses;
    key(4'hE);
    key(4'd5);
    key(4'hB);
    n_chk++; if (busy !== 1'b1 || bcd1 !== 16'h0001 || bcd2 !== 16'h0002 || op_selected !== 2'b01) begin n_fail++; $display("FAIL t5_drop got %b/%h/%h/%b exp 1/0001/0002/01", busy, bcd1, bcd2, op_selected); end
    tick();
    n_chk++; if (busy !== 1'b0 || display_bcd !== 16'h0003 || pulses - p0 !== 1) begin n_fail++; $display("FAIL t5_res got %b/%h/%0d exp 0/0003/1", busy, display_bcd, pulses - p0); end
    do_clear();
    key(4'd1); key(4'hA); key(4'd2);
    p0 = pulses;
    key(4'hE); tick();
    key(4'hC);
    n_chk++; if (busy !== 1'b0 || bcd1 !== 16'h0 || bcd2 !== 16'h0 || op_selected !== 2'b00 || display_bcd !== 16'h0) begin n_fail++; $display("FAIL t5_abort got %b/%h/%h/%b/%h exp 0/0000/0000/00/0000", busy, bcd1, bcd2, op_selected, display_bcd); end
    tick(); tick(); tick();
    n_chk++; if (pulses - p0 !== 1 || busy !== 1'b0) begin n_fail++; $display("FAIL t5_nopulse got %0d/%b exp 1/0", pulses - p0, busy); end
  endtask

  task automatic test_clear_priority();
    do_clear();
    key(4'd1); key(4'hA); key(4'd4); key(4'd5);
    clear = 1'b1; key_valid = 1'b1; key_code = 4'd7;
    tick();
    clear = 1'b0; key_valid = 1'b0;
    test_reset();
  endtask

  task automatic test_b_empty();
    do_clear();
    key(4'd3); key(4'hA); key(4'hB);
    n_chk++; if (op_selected !== 2'b10) begin n_fail++; $display("FAIL t7_swap got %b exp 10", op_selected); end
    p0 = pulses;
    key(4'hE); tick();
    n_chk++; if (pulses != p0 || busy !== 1'b0 || display_bcd !== 16'h0003) begin n_fail++; $display("FAIL t7_noexec got %0d/%b/%h exp 0/0/0003", pulses - p0, busy, display_bcd); end
    key(4'd4); key(4'hA);
    n_chk++; if (op_selected !== 2'b10 || display_bcd !== 16'h0004) begin n_fail++; $display("FAIL t7_noswap got %b/%h exp 10/0004", op_selected, display_bcd); end
    key(4'hE);
    n_chk++; if (alu_enable !== 2'b01) begin n_fail++; $display("FAIL t7_exec got %b exp 01", alu_enable); end
    tick(); tick(); tick();
  endtask

  initial begin
    clear = 1'b1; key_valid = 1'b0; key_code = 4'd0; alu_bcd_out = 16'h0; alu_special = 1'b0;
    tick(); tick();
    clear = 1'b0;
    test_reset();
    test_add();
    test_sub_neg();
    test_digit_limit();
    test_chain();
    test_busy_keys();
    test_clear_priority();
    test_b_empty();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
